// File: rtl/predecode_queue.sv
// Instruction queue between prefetch and decode; each word is predecoded on push and stored with its flags.
// Define PREDECODE_BYPASS_EN to forward a word straight to the head outputs when the queue is empty.
module predecode_queue #(
    parameter int DEPTH      = 4,
    parameter int INST_BITS  = 16,
    parameter int CLASS_BITS = 3
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    in_valid_i,
    input  logic [INST_BITS-1:0]    in_inst_i,
    output logic                    in_ready_o,
    input  logic                    flush_i,
    output logic                    inst_valid_o,
    output logic [INST_BITS-1:0]    inst_o,
    output logic [CLASS_BITS-1:0]   pd_cls_o,
    output logic                    pd_wide_o,
    output logic                    pd_branch_o,
    output logic                    pd_use_imm8_o,
    output logic                    pd_src1_from_pc_o,
    input  logic                    inst_done_i,
    output logic                    next_valid_o,
    output logic                    next_branch_o,
    output logic [$clog2(DEPTH):0]  count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [CLASS_BITS-1:0] CLS_ALU   = CLASS_BITS'(0);
    localparam logic [CLASS_BITS-1:0] CLS_MOV   = CLASS_BITS'(1);
    localparam logic [CLASS_BITS-1:0] CLS_SWAP  = CLASS_BITS'(2);
    localparam logic [CLASS_BITS-1:0] CLS_SHIFT = CLASS_BITS'(3);

    typedef struct packed {
        logic [CLASS_BITS-1:0] cls;
        logic                  wide;
        logic                  branch;
        logic                  use_imm8;
        logic                  src1_pc;
    } pd_t;

    logic [INST_BITS-1:0] mem_q [DEPTH];
    pd_t                  pd_q  [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;

    pd_t        pd_in;
    logic       b8, e, m, d, z;
    logic [2:0] aaa, mdz;
    logic       full, push, pop, byp_act, byp_consume;

    // Field split {b8,e,aaa,m,rr,d,z,imm6}; rr and imm6 do not affect predecode.
    always_comb begin
        b8    = in_inst_i[INST_BITS-1];
        e     = in_inst_i[INST_BITS-2];
        aaa   = in_inst_i[INST_BITS-3 -: 3];
        m     = in_inst_i[INST_BITS-6];
        d     = in_inst_i[7];
        z     = in_inst_i[6];
        mdz   = {m, d, z};
        pd_in = '0;
        if (b8 | e) begin
            pd_in.wide = ~b8;
            pd_in.cls  = (mdz == 3'b111) ? CLS_SHIFT : CLS_ALU;
        end else if (aaa[2] | aaa[1]) begin
            pd_in.wide = ~aaa[2];
            if (!aaa[0]) begin
                pd_in.use_imm8 = 1'b1;
                pd_in.cls      = m ? CLS_MOV : CLS_ALU;
                pd_in.src1_pc  = ~m;
            end else if (mdz == 3'b101) begin
                pd_in.cls = CLS_SHIFT;
            end else if (mdz == 3'b111) begin
                pd_in.cls = CLS_SWAP;
            end else begin
                pd_in.cls = CLS_MOV;
            end
        end else begin
            pd_in.branch   = 1'b1;
            pd_in.wide     = 1'b1;
            pd_in.use_imm8 = 1'b1;
            pd_in.src1_pc  = 1'b1;
            pd_in.cls      = CLS_ALU;
        end
    end

    always_comb begin
        full        = (count_q == CNT_W'(DEPTH));
        byp_act     = 1'b0;
        byp_consume = 1'b0;
`ifdef PREDECODE_BYPASS_EN
        byp_act     = (count_q == '0) && in_valid_i && !flush_i;
        byp_consume = byp_act && inst_done_i;
`endif
        push     = in_valid_i && !full && !flush_i && !byp_consume;
        pop      = inst_done_i && (count_q != '0) && !flush_i;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
                pd_q[i]  <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= in_inst_i;
                pd_q[wr_ptr_q]  <= pd_in;
            end
        end
    end

    pd_t                  head_pd;
    logic [INST_BITS-1:0] head_inst;
    logic                 head_valid;
    logic [PTR_W-1:0]     nxt_ptr;

    // Head outputs are forced to zero whenever no entry is presented.
    always_comb begin
        head_valid = (count_q != '0);
        head_inst  = mem_q[rd_ptr_q];
        head_pd    = pd_q[rd_ptr_q];
        if (byp_act) begin
            head_valid = 1'b1;
            head_inst  = in_inst_i;
            head_pd    = pd_in;
        end
        nxt_ptr = rd_ptr_q + PTR_W'(1);

        in_ready_o        = ~full;
        inst_valid_o      = head_valid;
        inst_o            = head_valid ? head_inst : '0;
        pd_cls_o          = head_valid ? head_pd.cls : '0;
        pd_wide_o         = head_valid & head_pd.wide;
        pd_branch_o       = head_valid & head_pd.branch;
        pd_use_imm8_o     = head_valid & head_pd.use_imm8;
        pd_src1_from_pc_o = head_valid & head_pd.src1_pc;
        next_valid_o      = (count_q >= CNT_W'(2));
        next_branch_o     = next_valid_o & pd_q[nxt_ptr].branch;
        count_o           = count_q;
    end

endmodule
